// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and defaults for the DDR read/write arbiter.
// Holds the FSM state encoding, the grant encoding and parameter defaults.
package ddr_arb_pkg;

    localparam int AXI_WIDTH_DEF = 64;
    localparam int ADDR_W_DEF    = 30;
    localparam int LEN_W_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_WAIT,
        ST_RD_CMD,
        ST_RD_WAIT
    } arb_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: burst start-address pointer for one arbiter path.
// Ports: clk/rst; beg_addr/end_addr region bounds; len burst length (N+1);
//   grant samples the start, advance steps by one burst (wrapping at end),
//   load_beg re-arms the pointer to the region start; addr current start;
//   wrap pulses on the advance cycle that returns the pointer to beg_addr.
module burst_addr_gen
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int BEAT_BYTES = AXI_WIDTH_DEF / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] beg_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              grant,
    input  logic              advance,
    input  logic              load_beg,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    localparam int AW1 = ADDR_W + 1;

    logic [ADDR_W-1:0] ptr_q;
    logic              fresh_q;
    logic [ADDR_W:0]   burst_bytes;
    logic [ADDR_W:0]   next_addr;
    logic [ADDR_W:0]   next_last;
    logic              overflow;

    // One extra bit keeps the end-of-next-burst sum from overflowing.
    assign burst_bytes = (AW1'(len) + AW1'(1)) * AW1'(BEAT_BYTES);
    assign next_addr   = {1'b0, ptr_q} + burst_bytes;
    assign next_last   = next_addr + burst_bytes - AW1'(1);
    assign overflow    = next_last > {1'b0, end_addr};

    assign wrap = advance & overflow;

    // While fresh, the pointer tracks beg_addr live; the grant freezes it.
    assign addr = fresh_q ? beg_addr : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            fresh_q <= 1'b1;
        end else if (load_beg) begin
            fresh_q <= 1'b1;
        end else if (advance) begin
            fresh_q <= 1'b0;
            ptr_q   <= overflow ? beg_addr : next_addr[ADDR_W-1:0];
        end else if (grant && fresh_q) begin
            fresh_q <= 1'b0;
            ptr_q   <= beg_addr;
        end
    end

endmodule

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: round-robin arbiter issuing write/read burst commands to MIG.
// Ports: clk/rst; region bounds and burst lengths per path; wr_req/rd_req,
//   rd_mem_enable; cmd valid/ready/addr/len and done per path; wrap pulses; busy.
module ddr_rw_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int AXI_WIDTH = AXI_WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wr_beg_addr,
    input  logic [ADDR_W-1:0] wr_end_addr,
    input  logic [ADDR_W-1:0] rd_beg_addr,
    input  logic [ADDR_W-1:0] rd_end_addr,
    input  logic [LEN_W-1:0]  wr_burst_len,
    input  logic [LEN_W-1:0]  rd_burst_len,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              rd_mem_enable,
    output logic              wr_cmd_valid,
    input  logic              wr_cmd_ready,
    output logic [ADDR_W-1:0] wr_cmd_addr,
    output logic [LEN_W-1:0]  wr_cmd_len,
    input  logic              wr_done,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [LEN_W-1:0]  rd_cmd_len,
    input  logic              rd_done,
    output logic              wr_wrap,
    output logic              rd_wrap,
    output logic              busy
);

    localparam int BEAT_BYTES = AXI_WIDTH / 8;

    arb_state_t       state_q;
    arb_state_t       state_d;
    grant_t           last_q;
    logic             wr_elig;
    logic             rd_elig;
    logic             grant_wr;
    logic             grant_rd;
    logic [LEN_W-1:0] wr_len_q;
    logic [LEN_W-1:0] rd_len_q;
    logic             wr_adv;
    logic             rd_adv;
    logic             rd_active;
    logic             rd_load;

    assign wr_elig = wr_req;
    assign rd_elig = rd_req & rd_mem_enable;

    always_comb begin
        state_d  = state_q;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_elig && (!rd_elig || last_q == GNT_RD)) begin
                    grant_wr = 1'b1;
                    state_d  = ST_WR_CMD;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                    state_d  = ST_RD_CMD;
                end
            end
            ST_WR_CMD: begin
                if (wr_cmd_ready) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (wr_done) state_d = ST_IDLE;
            end
            ST_RD_CMD: begin
                if (rd_cmd_ready) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rd_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= GNT_RD;
            wr_len_q <= '0;
            rd_len_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_wr) begin
                last_q   <= GNT_WR;
                wr_len_q <= wr_burst_len;
            end
            if (grant_rd) begin
                last_q   <= GNT_RD;
                rd_len_q <= rd_burst_len;
            end
        end
    end

    assign wr_cmd_valid = state_q == ST_WR_CMD;
    assign rd_cmd_valid = state_q == ST_RD_CMD;
    assign busy         = state_q != ST_IDLE;
    assign wr_cmd_len   = wr_len_q;
    assign rd_cmd_len   = rd_len_q;

    assign wr_adv    = wr_done & (state_q == ST_WR_WAIT);
    assign rd_active = (state_q == ST_RD_CMD) | (state_q == ST_RD_WAIT);
    assign rd_adv    = rd_done & (state_q == ST_RD_WAIT) & rd_mem_enable;

    // A disabled read path parks at its start, but never mid-burst:
    // an in-flight read finishes first and only then reloads.
    assign rd_load = ~rd_mem_enable
                   & (~rd_active | (rd_done & (state_q == ST_RD_WAIT)));

    burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_wr_gen (
        .clk      (clk),
        .rst      (rst),
        .beg_addr (wr_beg_addr),
        .end_addr (wr_end_addr),
        .len      (wr_len_q),
        .grant    (grant_wr),
        .advance  (wr_adv),
        .load_beg (1'b0),
        .addr     (wr_cmd_addr),
        .wrap     (wr_wrap)
    );

    burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_rd_gen (
        .clk      (clk),
        .rst      (rst),
        .beg_addr (rd_beg_addr),
        .end_addr (rd_end_addr),
        .len      (rd_len_q),
        .grant    (grant_rd),
        .advance  (rd_adv),
        .load_beg (rd_load),
        .addr     (rd_cmd_addr),
        .wrap     (rd_wrap)
    );

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: directed and randomized bench for ddr_rw_arbiter.
// A transaction-level model predicts grants, addresses, lengths and wraps.
module tb_ddr_rw_arbiter;

    localparam int AW = 30;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wr_beg_addr = '0;
    logic [AW-1:0] wr_end_addr = '0;
    logic [AW-1:0] rd_beg_addr = '0;
    logic [AW-1:0] rd_end_addr = '0;
    logic [LW-1:0] wr_burst_len = '0;
    logic [LW-1:0] rd_burst_len = '0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          rd_mem_enable = 1'b0;
    logic          wr_cmd_valid;
    logic          wr_cmd_ready = 1'b0;
    logic [AW-1:0] wr_cmd_addr;
    logic [LW-1:0] wr_cmd_len;
    logic          wr_done = 1'b0;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready = 1'b0;
    logic [AW-1:0] rd_cmd_addr;
    logic [LW-1:0] rd_cmd_len;
    logic          rd_done = 1'b0;
    logic          wr_wrap;
    logic          rd_wrap;
    logic          busy;

    always #5 clk = ~clk;

    ddr_rw_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .wr_beg_addr   (wr_beg_addr),
        .wr_end_addr   (wr_end_addr),
        .rd_beg_addr   (rd_beg_addr),
        .rd_end_addr   (rd_end_addr),
        .wr_burst_len  (wr_burst_len),
        .rd_burst_len  (rd_burst_len),
        .wr_req        (wr_req),
        .rd_req        (rd_req),
        .rd_mem_enable (rd_mem_enable),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_len    (wr_cmd_len),
        .wr_done       (wr_done),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_len    (rd_cmd_len),
        .rd_done       (rd_done),
        .wr_wrap       (wr_wrap),
        .rd_wrap       (rd_wrap),
        .busy          (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // Model: path 0 none, 1 write, 2 read; phase 0 command, 1 waiting done.
    int          m_path;
    int          m_phase;
    bit          m_last_rd;
    logic [63:0] m_wr_ptr;
    logic [63:0] m_rd_ptr;
    bit          m_wr_fresh;
    bit          m_rd_fresh;
    logic [63:0] m_wr_len;
    logic [63:0] m_rd_len;

    typedef struct {
        int          path;
        logic [63:0] addr;
    } acc_t;

    acc_t obs[$];
    int   wrap_wr_seen;
    int   wrap_rd_seen;
    int   rd_valid_cycles;

    task automatic model_reset();
        m_path     = 0;
        m_phase    = 0;
        m_last_rd  = 1'b1;
        m_wr_ptr   = '0;
        m_rd_ptr   = '0;
        m_wr_fresh = 1'b1;
        m_rd_fresh = 1'b1;
        m_wr_len   = '0;
        m_rd_len   = '0;
    endtask

    function automatic logic [63:0] bytes_of(input logic [63:0] len);
        return (len + 64'd1) * 64'd8;
    endfunction

    function automatic bit wraps(input logic [63:0] ptr,
                                 input logic [63:0] len,
                                 input logic [63:0] end_a);
        logic [63:0] b;
        b = bytes_of(len);
        return (ptr + b + b - 64'd1) > end_a;
    endfunction

    function automatic logic [63:0] obs_addr(input int i);
        if (i < obs.size()) return obs[i].addr;
        return '1;
    endfunction

    function automatic int obs_path(input int i);
        if (i < obs.size()) return obs[i].path;
        return -1;
    endfunction

    // Called at a negedge with inputs already driven; ends at next negedge.
    task automatic tick();
        logic [63:0] nx;
        bit          we;
        bit          re;
        bit          rd_act_pre;
        bit          e_wwrap;
        bit          e_rwrap;
        #1;
        e_wwrap = m_path == 1 && m_phase == 1 && wr_done
               && wraps(m_wr_ptr, m_wr_len, 64'(wr_end_addr));
        e_rwrap = m_path == 2 && m_phase == 1 && rd_done && rd_mem_enable
               && wraps(m_rd_ptr, m_rd_len, 64'(rd_end_addr));
        check("wr_cmd_valid", 64'(wr_cmd_valid),
              64'(m_path == 1 && m_phase == 0));
        check("rd_cmd_valid", 64'(rd_cmd_valid),
              64'(m_path == 2 && m_phase == 0));
        check("busy", 64'(busy), 64'(m_path != 0));
        check("wr_cmd_addr", 64'(wr_cmd_addr),
              m_wr_fresh ? 64'(wr_beg_addr) : m_wr_ptr);
        check("rd_cmd_addr", 64'(rd_cmd_addr),
              m_rd_fresh ? 64'(rd_beg_addr) : m_rd_ptr);
        check("wr_cmd_len", 64'(wr_cmd_len), m_wr_len);
        check("rd_cmd_len", 64'(rd_cmd_len), m_rd_len);
        check("wr_wrap", 64'(wr_wrap), 64'(e_wwrap));
        check("rd_wrap", 64'(rd_wrap), 64'(e_rwrap));
        if (wr_cmd_valid && wr_cmd_ready)
            obs.push_back('{0, 64'(wr_cmd_addr)});
        if (rd_cmd_valid && rd_cmd_ready)
            obs.push_back('{1, 64'(rd_cmd_addr)});
        if (wr_wrap) wrap_wr_seen++;
        if (rd_wrap) wrap_rd_seen++;
        if (rd_cmd_valid) rd_valid_cycles++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            rd_act_pre = m_path == 2;
            case (m_path)
                0: begin
                    we = wr_req;
                    re = rd_req && rd_mem_enable;
                    if (we && (!re || m_last_rd)) begin
                        m_path    = 1;
                        m_phase   = 0;
                        m_last_rd = 1'b0;
                        m_wr_len  = 64'(wr_burst_len);
                        if (m_wr_fresh) begin
                            m_wr_ptr   = 64'(wr_beg_addr);
                            m_wr_fresh = 1'b0;
                        end
                    end else if (re) begin
                        m_path    = 2;
                        m_phase   = 0;
                        m_last_rd = 1'b1;
                        m_rd_len  = 64'(rd_burst_len);
                        if (m_rd_fresh) begin
                            m_rd_ptr   = 64'(rd_beg_addr);
                            m_rd_fresh = 1'b0;
                        end
                    end
                end
                1: begin
                    if (m_phase == 0) begin
                        if (wr_cmd_ready) m_phase = 1;
                    end else if (wr_done) begin
                        nx = m_wr_ptr + bytes_of(m_wr_len);
                        if (wraps(m_wr_ptr, m_wr_len, 64'(wr_end_addr)))
                            m_wr_ptr = 64'(wr_beg_addr);
                        else
                            m_wr_ptr = nx;
                        m_path = 0;
                    end
                end
                default: begin
                    if (m_phase == 0) begin
                        if (rd_cmd_ready) m_phase = 1;
                    end else if (rd_done) begin
                        if (rd_mem_enable) begin
                            nx = m_rd_ptr + bytes_of(m_rd_len);
                            if (wraps(m_rd_ptr, m_rd_len, 64'(rd_end_addr)))
                                m_rd_ptr = 64'(rd_beg_addr);
                            else
                                m_rd_ptr = nx;
                        end else begin
                            m_rd_fresh = 1'b1;
                        end
                        m_path = 0;
                    end
                end
            endcase
            if (!rd_mem_enable && !rd_act_pre) m_rd_fresh = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic auto_done();
        wr_done = m_path == 1 && m_phase == 1;
        rd_done = m_path == 2 && m_phase == 1;
    endtask

    task automatic run_acc(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && obs.size() < n; i++) begin
            auto_done();
            tick();
        end
        wr_done = 1'b0;
        rd_done = 1'b0;
        check(tag, 64'(obs.size()), 64'(n));
    endtask

    task automatic finish_burst(input string tag);
        for (int i = 0; i < 40 && m_path != 0; i++) begin
            auto_done();
            tick();
        end
        wr_done = 1'b0;
        rd_done = 1'b0;
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    int cnt_v;
    int cnt_a;

    initial begin
        model_reset();
        wr_end_addr  = 30'd4915199;
        rd_end_addr  = 30'd4915199;
        wr_burst_len = 8'd31;
        rd_burst_len = 8'd31;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Sequential writes from region start.
        wr_req       = 1'b1;
        wr_cmd_ready = 1'b1;
        obs.delete();
        run_acc(3, 40, "seq_count");
        check("seq_a0", obs_addr(0), 64'd0);
        check("seq_a1", obs_addr(1), 64'd256);
        check("seq_a2", obs_addr(2), 64'd512);

        // Wrap at the top of the 4915199 region, entered from near the end.
        wr_req      = 1'b0;
        finish_burst("wrap_idle");
        wr_beg_addr = 30'd4914688;
        do_reset();
        wr_req       = 1'b1;
        wrap_wr_seen = 0;
        obs.delete();
        run_acc(1, 20, "wrap_first");
        wr_beg_addr = '0;
        run_acc(3, 40, "wrap_count");
        check("wrap_a0", obs_addr(0), 64'd4914688);
        check("wrap_a1", obs_addr(1), 64'd4914944);
        check("wrap_a2", obs_addr(2), 64'd0);
        check("wrap_pulses", 64'(wrap_wr_seen), 64'd1);

        // Round robin with both requests held high.
        wr_req = 1'b0;
        do_reset();
        wr_req        = 1'b1;
        rd_req        = 1'b1;
        rd_mem_enable = 1'b1;
        rd_cmd_ready  = 1'b1;
        obs.delete();
        run_acc(6, 80, "rr_count");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_path%0d", i), 64'(obs_path(i)), 64'(i % 2));
            check($sformatf("rr_addr%0d", i), obs_addr(i),
                  64'((i / 2) * 256));
        end

        // Read command held off by ready for ten cycles.
        wr_req = 1'b0;
        rd_req = 1'b0;
        do_reset();
        rd_req          = 1'b1;
        rd_cmd_ready    = 1'b0;
        rd_valid_cycles = 0;
        obs.delete();
        for (int i = 0; i < 40 && obs.size() < 1; i++) begin
            rd_cmd_ready = rd_valid_cycles >= 10;
            tick();
        end
        check("hold_cycles", 64'(rd_valid_cycles), 64'd11);
        check("hold_addr", obs_addr(0), 64'd0);
        rd_req       = 1'b0;
        rd_cmd_ready = 1'b1;
        finish_burst("hold_idle");

        // Read enable dropped while waiting on the burst at 1024.
        do_reset();
        rd_req       = 1'b1;
        wrap_rd_seen = 0;
        obs.delete();
        run_acc(5, 60, "en_count");
        check("en_a4", obs_addr(4), 64'd1024);
        rd_mem_enable = 1'b0;
        rd_req        = 1'b0;
        rd_done       = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        check("en_addr_after", 64'(rd_cmd_addr), 64'd0);
        check("en_no_wrap", 64'(wrap_rd_seen), 64'd0);
        rd_mem_enable = 1'b1;
        rd_req        = 1'b1;
        obs.delete();
        run_acc(1, 20, "en_resume");
        check("en_resume_a", obs_addr(0), 64'd0);
        rd_req = 1'b0;
        finish_burst("en_idle");

        // Read requests with the read path disabled.
        rd_mem_enable = 1'b0;
        rd_req        = 1'b1;
        cnt_v         = 0;
        cnt_a         = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd_cmd_valid) cnt_v++;
            if (rd_cmd_addr != '0) cnt_a++;
        end
        check("dis_valid", 64'(cnt_v), 64'd0);
        check("dis_addr", 64'(cnt_a), 64'd0);
        rd_req = 1'b0;

        // Asynchronous reset while waiting on the write burst at 2048.
        do_reset();
        wr_req = 1'b1;
        obs.delete();
        run_acc(9, 60, "rst_count");
        check("rst_a8", obs_addr(8), 64'd2048);
        wr_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(wr_cmd_valid), 64'd0);
        check("rst_addr", 64'(wr_cmd_addr), 64'd0);
        model_reset();
        @(negedge clk);
        rst    = 1'b0;
        wr_req = 1'b1;
        obs.delete();
        run_acc(1, 20, "rst_next");
        check("rst_next_a", obs_addr(0), 64'd0);
        wr_req = 1'b0;
        finish_burst("rst_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                wr_beg_addr = 30'($urandom_range(0, 1000) * 8);
                wr_end_addr = wr_beg_addr + 30'($urandom_range(64, 2000));
                rd_beg_addr = 30'($urandom_range(0, 1000) * 8);
                rd_end_addr = rd_beg_addr + 30'($urandom_range(64, 2000));
            end
            wr_burst_len = 8'($urandom_range(0, 7));
            rd_burst_len = 8'($urandom_range(0, 7));
            wr_req       = ($urandom % 4) != 0;
            rd_req       = ($urandom % 4) != 0;
            if (($urandom % 50) == 0) rd_mem_enable = ~rd_mem_enable;
            wr_cmd_ready = ($urandom % 2) != 0;
            rd_cmd_ready = ($urandom % 2) != 0;
            if (m_path == 1 && m_phase == 1)
                wr_done = ($urandom % 3) == 0;
            else
                wr_done = ($urandom % 10) == 0;
            if (m_path == 2 && m_phase == 1)
                rd_done = ($urandom % 3) == 0;
            else
                rd_done = ($urandom % 10) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_rw_arbiter.md
DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

Interface
REQ-001 Parameter AXI_WIDTH, default 64: AXI data width in bits; one beat = AXI_WIDTH/8 bytes.
REQ-002 Parameter ADDR_W, default 30: byte-address width.
REQ-003 Parameter LEN_W, default 8: burst-length field width; encoded length N means N+1 beats.
REQ-004 clk  in  1: single clock (MIG ui_clk); all logic is in this domain.
REQ-005 rst  in  1: reset, asynchronous and active-high.
REQ-006 wr_beg_addr, wr_end_addr  in  ADDR_W each: write region bounds, inclusive byte addresses.
REQ-007 rd_beg_addr, rd_end_addr  in  ADDR_W each: read region bounds, inclusive byte addresses.
REQ-008 wr_burst_len, rd_burst_len  in  LEN_W each: burst lengths, encoded N+1.
REQ-009 wr_req  in  1: write FIFO holds at least one full burst.
REQ-010 rd_req  in  1: read FIFO has room for one full burst.
REQ-011 rd_mem_enable  in  1: read path enable.
REQ-012 wr_cmd_valid / wr_cmd_ready  out / in  1 each: write command handshake.
REQ-013 wr_cmd_addr  out  ADDR_W: write command start address.
REQ-014 wr_cmd_len  out  LEN_W: write command burst length.
REQ-015 wr_done  in  1: one-cycle pulse; write burst complete (B response received).
REQ-016 rd_cmd_valid, rd_cmd_ready, rd_cmd_addr, rd_cmd_len, rd_done: read equivalents of REQ-012..REQ-015, same directions and widths.
REQ-017 wr_wrap, rd_wrap  out  1 each: one-cycle pulse when the corresponding pointer wraps to its region start.
REQ-018 busy  out  1: high in every state except IDLE.

Function
REQ-019 FSM states are IDLE, WR_CMD, WR_WAIT, RD_CMD and RD_WAIT.
REQ-020 IDLE -> WR_CMD when wr_req is the only eligible request.
REQ-021 IDLE -> RD_CMD when (rd_req & rd_mem_enable) is the only eligible request.
REQ-022 When both requests are eligible in IDLE, the grant goes to the path not granted last (round-robin); last_grant resets to RD, so write wins first.
REQ-023 In xx_CMD, xx_cmd_valid is high and addr/len are stable; the FSM moves to xx_WAIT on the cycle valid&ready is sampled high.
REQ-024 xx_cmd_valid rises the cycle after the IDLE grant; it never drops before ready.
REQ-025 xx_WAIT -> IDLE on xx_done.
REQ-026 xx_done outside the matching WAIT state is ignored.
REQ-027 Minimum of one IDLE cycle between consecutive bursts.
REQ-028 xx_cmd_len is the value of xx_burst_len captured at the grant cycle.
REQ-029 Each burst is (len+1)*AXI_WIDTH/8 bytes; the pointer advances by that amount on the xx_done cycle.
REQ-030 Wrap rule: if next + bytes - 1 > end_addr, then next = beg_addr and xx_wrap pulses on the same cycle as the advance.
REQ-031 Address arithmetic is done at ADDR_W+1 bits so no overflow occurs before the comparison.
REQ-032 While rd_mem_enable is low, the read pointer is held at rd_beg_addr and no read grant is issued.
REQ-033 If rd_mem_enable falls during RD_CMD or RD_WAIT, the burst completes normally; the read pointer then loads rd_beg_addr instead of advancing, and rd_wrap stays low.
REQ-034 Region bounds are sampled only at grant, advance and wrap; changing them mid-burst has no effect on the burst in flight.

Reset
REQ-035 Reset is asynchronous and active-high.
REQ-036 On rst the FSM enters IDLE and all cmd_valid, wrap and busy outputs are 0.
REQ-037 On rst wr_cmd_addr = wr_beg_addr, rd_cmd_addr = rd_beg_addr, cmd_len = 0 and last_grant = RD.
REQ-038 Reset asserted mid-burst abandons the burst; the pointers restart at the region start.

Structure
REQ-039 Package ddr_arb_pkg holds the FSM state encoding, the grant encoding (GNT_WR, GNT_RD) and the parameter defaults.
REQ-040 Sub-module burst_addr_gen (pointer register, advance, wrap, wrap pulse, sync load-to-begin) is instantiated once per path.

Verification
REQ-041 Config: beg=0, end=4915199, len=31, AXI_WIDTH=64 (256 B per burst). wr_req only, ready tied high -> addresses 0, 256, 512, ...; the 19200th burst is at 4914944; then wr_wrap pulses and the next address is 0.
REQ-042 wr_req and rd_req (with enable) held high -> grants alternate WR, RD, WR, ..., starting with WR after reset.
REQ-043 rd_cmd_ready held low for 10 cycles -> rd_cmd_valid stays high with a constant address; RD_WAIT is entered on the 11th cycle.
REQ-044 rd_mem_enable dropped in RD_WAIT at address 1024 -> the burst finishes and the next read address is 0.
REQ-045 rd_req high with rd_mem_enable low for 100 cycles -> no rd_cmd_valid; rd_cmd_addr = 0 throughout.
REQ-046 rst pulsed during WR_WAIT at address 2048 -> wr_cmd_valid and busy go low asynchronously; the next write is at address 0.
